// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR with prescaled free-run / single-step, lock-up recovery, period measurement
// and a registered active-low hex seven-segment driver (seg lags state by one cycle; no backpressure).
module lfsr_hex_display #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'h01),
  parameter int               DIV     = 1,
  parameter bit               RECOVER = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   run,
  input  logic                   step,
  output logic [WIDTH-1:0]       state,
  output logic                   lockup,
  output logic [15:0]            period,
  output logic                   period_valid,
  output logic [8*(WIDTH/4)-1:0] seg
);

  localparam int NDIG = WIDTH / 4;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [WIDTH-1:0]    start;
  logic [15:0]         step_cnt;
  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic                fb;
  logic [WIDTH-1:0]    state_shift;
  logic [8*NDIG-1:0]   seg_nxt;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'h03;
      4'h1: hex7 = 8'h9F;
      4'h2: hex7 = 8'h25;
      4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h49;
      4'h6: hex7 = 8'h41;
      4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01;
      4'h9: hex7 = 8'h09;
      4'hA: hex7 = 8'h11;
      4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63;
      4'hD: hex7 = 8'h85;
      4'hE: hex7 = 8'h61;
      default: hex7 = 8'h71;
    endcase
  endfunction

  assign lockup      = (state == '0);
  assign fb          = ^(state & TAPS);
  assign state_shift = {fb, state[WIDTH-1:1]};
  // step is only honoured in step mode; in free-run the prescaler alone decides
  assign tick        = run ? (div_cnt == DIV_LAST) : step;

  always_comb begin
    seg_nxt = '1;
    for (int k = 0; k < NDIG; k++) begin
      seg_nxt[8*k +: 8] = hex7(state[4*k +: 4]);
    end
    seg_nxt[0] = ~lockup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEED;
      start        <= SEED;
      step_cnt     <= '0;
      div_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      seg          <= '1;
    end else begin
      seg          <= seg_nxt;
      period_valid <= 1'b0;
      if (load) begin
        state    <= seed;
        start    <= seed;
        step_cnt <= '0;
        div_cnt  <= '0;
      end else begin
        if (run) begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end else begin
          div_cnt <= '0;
        end
        if (tick) begin
          if (!lockup) begin
            state    <= state_shift;
            step_cnt <= step_cnt + 16'd1;
            // period counts shifts, so the wrapping shift itself is included
            if (state_shift == start) begin
              period       <= step_cnt + 16'd1;
              period_valid <= 1'b1;
              step_cnt     <= '0;
            end
          end else if (RECOVER) begin
            state    <= SEED;
            start    <= SEED;
            step_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Directed bench for lfsr_hex_display: 8-bit DIV=1 recovering, 8-bit DIV=4 non-recovering,
// and 16-bit maximal-length instances driven from one sequence.
module tb_lfsr_hex_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // instance A: defaults
  logic        a_load = 0, a_run = 0, a_step = 0;
  logic [7:0]  a_seed = 0, a_state;
  logic        a_lockup, a_pv;
  logic [15:0] a_period, a_seg;

  lfsr_hex_display #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(1), .RECOVER(1'b1)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .seed(a_seed), .run(a_run), .step(a_step),
    .state(a_state), .lockup(a_lockup), .period(a_period), .period_valid(a_pv), .seg(a_seg)
  );

  // instance B: prescaled, no recovery
  logic        b_load = 0, b_run = 0, b_step = 0;
  logic [7:0]  b_seed = 0, b_state;
  logic        b_lockup, b_pv;
  logic [15:0] b_period, b_seg;

  lfsr_hex_display #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DIV(4), .RECOVER(1'b0)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .seed(b_seed), .run(b_run), .step(b_step),
    .state(b_state), .lockup(b_lockup), .period(b_period), .period_valid(b_pv), .seg(b_seg)
  );

  // instance C: 16-bit
  logic        c_load = 0, c_run = 0, c_step = 0;
  logic [15:0] c_seed = 0, c_state;
  logic        c_lockup, c_pv;
  logic [15:0] c_period;
  logic [31:0] c_seg;

  lfsr_hex_display #(.WIDTH(16), .TAPS(16'h002D), .SEED(16'h0001), .DIV(1), .RECOVER(1'b1)) u_c (
    .clk(clk), .rst(rst), .load(c_load), .seed(c_seed), .run(c_run), .step(c_step),
    .state(c_state), .lockup(c_lockup), .period(c_period), .period_valid(c_pv), .seg(c_seg)
  );

  logic [7:0] step_exp [5];
  int cnt;

  initial begin
    step_exp[0] = 8'h80; step_exp[1] = 8'h40; step_exp[2] = 8'h20;
    step_exp[3] = 8'h10; step_exp[4] = 8'h88;

    // reset defaults
    rst = 1'b1;
    cyc();
    check("rst_state", 32'(a_state), 32'h01);
    check("rst_lockup", 32'(a_lockup), 32'h0);
    check("rst_seg_blank", 32'(a_seg), 32'hFFFF);
    check("rst_period", 32'(a_period), 32'h0);
    check("rst_pv", 32'(a_pv), 32'h0);
    rst = 1'b0;
    cyc();
    check("seed_seg", 32'(a_seg), 32'h039F);

    // step mode
    for (int i = 0; i < 5; i++) begin
      a_step = 1'b1;
      cyc();
      check($sformatf("step_%0d", i), 32'(a_state), 32'(step_exp[i]));
      a_step = 1'b0;
      cyc();
      check($sformatf("step_hold_%0d", i), 32'(a_state), 32'(step_exp[i]));
    end
    check("seg_88", 32'(a_seg), 32'h0101);

    // free run DIV=1, period 255 twice
    a_seed = 8'h01; a_load = 1'b1; a_run = 1'b1;
    cyc();
    check("a_load_state", 32'(a_state), 32'h01);
    a_load = 1'b0;
    cnt = 0;
    do begin cyc(); cnt++; end while (!a_pv && cnt < 400);
    check("a_period_cycles", 32'(cnt), 32'd255);
    check("a_period", 32'(a_period), 32'd255);
    check("a_wrap_state", 32'(a_state), 32'h01);
    cnt = 0;
    do begin cyc(); cnt++; end while (!a_pv && cnt < 400);
    check("a_period_cycles2", 32'(cnt), 32'd255);
    check("a_period2", 32'(a_period), 32'd255);
    a_run = 1'b0;

    // lock-up with recovery
    a_seed = 8'h00; a_load = 1'b1;
    cyc();
    check("a_lock_state", 32'(a_state), 32'h00);
    check("a_lockup", 32'(a_lockup), 32'h1);
    a_load = 1'b0;
    cyc();
    check("a_lock_seg", 32'(a_seg), 32'h0302);
    a_step = 1'b1;
    cyc();
    a_step = 1'b0;
    check("a_recover_state", 32'(a_state), 32'h01);
    check("a_recover_lockup", 32'(a_lockup), 32'h0);
    check("a_recover_pv", 32'(a_pv), 32'h0);

    // DIV=4 with step held high (ignored in run mode)
    b_seed = 8'h01; b_load = 1'b1; b_run = 1'b1; b_step = 1'b1;
    cyc();
    b_load = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("b_hold3", 32'(b_state), 32'h01);
    cyc();
    check("b_shift4", 32'(b_state), 32'h80);
    cyc(); cyc();
    // mid-count load restarts phase
    b_seed = 8'h80; b_load = 1'b1;
    cyc();
    b_load = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check("b_reload_hold3", 32'(b_state), 32'h80);
    cyc();
    check("b_reload_shift4", 32'(b_state), 32'h40);

    // lock-up without recovery
    b_run = 1'b0; b_seed = 8'h00; b_load = 1'b1;
    cyc();
    b_load = 1'b0; b_step = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    b_step = 1'b0;
    check("b_locked_state", 32'(b_state), 32'h00);
    check("b_locked_lockup", 32'(b_lockup), 32'h1);

    // 16-bit: seg decode and full period
    c_seed = 16'hACE1; c_load = 1'b1;
    cyc();
    check("c_load_state", 32'(c_state), 32'h0000ACE1);
    c_load = 1'b0;
    cyc();
    check("c_seg", c_seg, 32'h1163619F);
    c_run = 1'b1;
    cnt = 0;
    do begin cyc(); cnt++; end while (!c_pv && cnt < 70000);
    check("c_period_cycles", 32'(cnt), 32'd65535);
    check("c_period", 32'(c_period), 32'd65535);
    check("c_wrap_state", 32'(c_state), 32'h0000ACE1);

    // reset mid-run
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("c_rst_state", 32'(c_state), 32'h0001);
    check("c_rst_period", 32'(c_period), 32'h0);
    check("c_rst_pv", 32'(c_pv), 32'h0);
    check("c_rst_seg", c_seg, 32'hFFFFFFFF);
    rst = 1'b0;
    c_run = 1'b0;
    cyc();
    check("c_rst_seg_seed", c_seg, 32'h0303039F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
